// File: rtl/int_ctrl.sv
// int_ctrl: trap sequencer for ecall/ebreak/mret and external IRQs; INT_CTRL_VECTORED_EN enables vectored IRQ targets.
// Latency: accept in N, CSR writes N+1..N+3, redirect N+4 (mret: write N+1, redirect N+2).
// Backpressure: hold_flag_o stalls the pipeline from the accept cycle until the redirect cycle inclusive.
module int_ctrl #(
    parameter int INT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      data_o,
    output logic             hold_flag_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MSTATUS,
        S_ASSERT,
        S_W_MRET,
        S_ASSERT_MRET
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_epc;
    logic [31:0] r_cause;

    logic        w_is_ecall;
    logic        w_is_ebreak;
    logic        w_is_mret;
    logic        w_async;
    logic        w_can_accept;
    logic        w_accept_mret;
    logic        w_accept_trap;
    logic [31:0] w_cause_new;
    logic [31:0] w_mst_trap;
    logic [31:0] w_mst_mret;
    logic [31:0] w_vec_base;
    logic [31:0] w_trap_addr;

    assign w_is_ecall  = (inst_i == INST_ECALL);
    assign w_is_ebreak = (inst_i == INST_EBREAK);
    assign w_is_mret   = (inst_i == INST_MRET);
    assign w_async     = (|int_flag_i) && csr_mstatus_i[3];

    // Reset also blocks acceptance so every output reads 0 while rst is high.
    assign w_can_accept  = (r_state == S_IDLE) && !jump_flag_i && !rst;
    assign w_accept_mret = w_can_accept && w_is_mret;
    assign w_accept_trap = w_can_accept && !w_is_mret
                           && (w_is_ecall || w_is_ebreak || w_async);

    assign w_cause_new = w_is_ecall  ? CAUSE_ECALL  :
                         w_is_ebreak ? CAUSE_EBREAK : CAUSE_EXT;

    // MPIE <- MIE, MIE <- 0 on trap entry; MIE <- MPIE, MPIE <- 1 on mret.
    assign w_mst_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                         1'b0, csr_mstatus_i[2:0]};
    assign w_mst_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                         csr_mstatus_i[7], csr_mstatus_i[2:0]};

    assign w_vec_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef INT_CTRL_VECTORED_EN
    assign w_trap_addr = ((csr_mtvec_i[1:0] == 2'b01) && r_cause[31])
                         ? (w_vec_base + {r_cause[29:0], 2'b00})
                         : w_vec_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^csr_mtvec_i[1:0];
    assign w_trap_addr   = w_vec_base;
`endif

    assign hold_flag_o = w_accept_mret || w_accept_trap || (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc   <= 32'd0;
            r_cause <= 32'd0;
        end else if (w_accept_trap) begin
            r_epc   <= inst_addr_i;
            r_cause <= w_cause_new;
        end
    end

    always_comb begin
        w_next       = r_state;
        we_o         = 1'b0;
        waddr_o      = 32'd0;
        data_o       = 32'd0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept_mret) begin
                    w_next = S_W_MRET;
                end else if (w_accept_trap) begin
                    w_next = S_W_MEPC;
                end
            end
            S_W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = {20'd0, CSR_MEPC};
                data_o  = r_epc;
                w_next  = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = {20'd0, CSR_MCAUSE};
                data_o  = r_cause;
                w_next  = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                we_o    = 1'b1;
                waddr_o = {20'd0, CSR_MSTATUS};
                data_o  = w_mst_trap;
                w_next  = S_ASSERT;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = w_trap_addr;
                w_next       = S_IDLE;
            end
            S_W_MRET: begin
                we_o    = 1'b1;
                waddr_o = {20'd0, CSR_MSTATUS};
                data_o  = w_mst_mret;
                w_next  = S_ASSERT_MRET;
            end
            S_ASSERT_MRET: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed test-plan scenarios plus randomized traffic against a sequence-offset reference model.
module tb_int_ctrl;
    localparam int INT_W = 8;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef INT_CTRL_VECTORED_EN
    localparam logic [31:0] EXP_VEC = 32'h0000_082C;
`else
    localparam logic [31:0] EXP_VEC = 32'h0000_0800;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [INT_W-1:0] int_flag_i;
    logic [31:0]      inst_i, inst_addr_i;
    logic             jump_flag_i;
    logic [31:0]      csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic             we_o, hold_flag_o, int_assert_o;
    logic [31:0]      waddr_o, data_o, int_addr_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: kind 0 = idle, 1 = trap sequence, 2 = mret sequence; k = cycles since accept.
    int          m_kind = 0;
    int          m_k    = 0;
    logic [31:0] m_epc, m_cause;
    logic [98:0] exp_v;
    wire  [98:0] w_obs = {we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o};

    always #5 clk = ~clk;

    int_ctrl #(.INT_W(INT_W)) dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .hold_flag_o(hold_flag_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    function automatic logic [98:0] pack(input logic we, input logic [31:0] a, input logic [31:0] d,
                                         input logic h, input logic s, input logic [31:0] ia);
        return {we, a, d, h, s, ia};
    endfunction

    // Drive one cycle's inputs at the falling edge, compute the expected outputs for that cycle.
    task automatic step(input logic r, input logic [INT_W-1:0] f, input logic [31:0] in,
                        input logic [31:0] pc, input logic j, input logic [31:0] tv,
                        input logic [31:0] ep, input logic [31:0] ms);
        logic        acc;
        logic [31:0] d;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; int_flag_i = f; inst_i = in; inst_addr_i = pc; jump_flag_i = j;
        csr_mtvec_i = tv; csr_mepc_i = ep; csr_mstatus_i = ms;
        exp_v = '0;
        if (r) begin
            m_kind = 0; m_k = 0; m_epc = 0; m_cause = 0;
        end else if (m_kind == 0) begin
            acc = 1'b0;
            if (!j) begin
                if (in == MRET) begin m_kind = 2; acc = 1'b1; end
                else if (in == ECALL) begin m_kind = 1; m_cause = 11; acc = 1'b1; end
                else if (in == EBREAK) begin m_kind = 1; m_cause = 3; acc = 1'b1; end
                else if (f != 0 && ms[3]) begin m_kind = 1; m_cause = 32'h8000000B; acc = 1'b1; end
            end
            if (acc) begin
                m_k = 1;
                if (m_kind == 1) m_epc = pc;
            end
            exp_v = pack(1'b0, 0, 0, acc, 1'b0, 0);
        end else begin
            if (m_kind == 1) begin
                case (m_k)
                    1: exp_v = pack(1'b1, 32'h341, m_epc, 1'b1, 1'b0, 0);
                    2: exp_v = pack(1'b1, 32'h342, m_cause, 1'b1, 1'b0, 0);
                    3: begin
                        d = ms; d[7] = ms[3]; d[3] = 1'b0;
                        exp_v = pack(1'b1, 32'h300, d, 1'b1, 1'b0, 0);
                    end
                    default: begin
                        tgt = tv & 32'hFFFF_FFFC;
`ifdef INT_CTRL_VECTORED_EN
                        if (tv[1:0] == 2'b01 && m_cause[31])
                            tgt = tgt + (m_cause & 32'h7FFF_FFFF) * 4;
`endif
                        exp_v = pack(1'b0, 0, 0, 1'b1, 1'b1, tgt);
                    end
                endcase
            end else begin
                if (m_k == 1) begin
                    d = ms; d[3] = ms[7]; d[7] = 1'b1;
                    exp_v = pack(1'b1, 32'h300, d, 1'b1, 1'b0, 0);
                end else begin
                    exp_v = pack(1'b0, 0, 0, 1'b1, 1'b1, ep);
                end
            end
            m_k++;
            if ((m_kind == 1 && m_k == 5) || (m_kind == 2 && m_k == 3)) begin
                m_kind = 0; m_k = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; int_flag_i = '0; inst_i = NOP; inst_addr_i = 0; jump_flag_i = 1'b0;
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
        #2;
        checks++;
        if (w_obs !== 99'd0) begin failures++; $display("FAIL reset_idle got=%h exp=0", w_obs); end
        inst_i = ECALL; csr_mstatus_i = 32'h8; int_flag_i = 8'hFF;
        #1;
        checks++;
        if (w_obs !== 99'd0) begin failures++; $display("FAIL reset_blocks_accept got=%h exp=0", w_obs); end
        m_kind = 0; m_k = 0; m_epc = 0; m_cause = 0;
        step(1'b0, 0, NOP, 0, 1'b0, 0, 0, 0);
        checks++;
        if (w_obs !== 99'd0) begin failures++; $display("FAIL reset_release got=%h exp=0", w_obs); end
    endtask

    task automatic test_ecall();
        logic [98:0] tbl [0:5];
        tbl[0] = pack(1'b0, 0, 0, 1'b1, 1'b0, 0);
        tbl[1] = pack(1'b1, 32'h341, 32'h100, 1'b1, 1'b0, 0);
        tbl[2] = pack(1'b1, 32'h342, 32'd11, 1'b1, 1'b0, 0);
        tbl[3] = pack(1'b1, 32'h300, 32'h80, 1'b1, 1'b0, 0);
        tbl[4] = pack(1'b0, 0, 0, 1'b1, 1'b1, 32'h800);
        tbl[5] = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 0, (i == 0) ? ECALL : NOP, 32'h100, 1'b0, 32'h800, 32'h0, 32'h8);
            checks++;
            if (w_obs !== tbl[i]) begin
                failures++; $display("FAIL ecall_seq cyc%0d got=%h exp=%h", i, w_obs, tbl[i]);
            end
        end
    endtask

    task automatic test_mret();
        logic [98:0] tbl [0:3];
        tbl[0] = pack(1'b0, 0, 0, 1'b1, 1'b0, 0);
        tbl[1] = pack(1'b1, 32'h300, 32'h88, 1'b1, 1'b0, 0);
        tbl[2] = pack(1'b0, 0, 0, 1'b1, 1'b1, 32'h104);
        tbl[3] = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, (i == 0) ? MRET : NOP, 32'h300, 1'b0, 32'h800, 32'h104, 32'h80);
            checks++;
            if (w_obs !== tbl[i]) begin
                failures++; $display("FAIL mret_seq cyc%0d got=%h exp=%h", i, w_obs, tbl[i]);
            end
        end
    endtask

    task automatic test_async();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i == 0) ? 8'h01 : 8'h00, NOP, 32'h200, 1'b0, 32'h800, 0, 32'h8);
            checks++;
            if (w_obs !== exp_v) begin
                failures++; $display("FAIL async_seq cyc%0d got=%h exp=%h", i, w_obs, exp_v);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (data_o !== ((i == 1) ? 32'h200 : 32'h8000000B)) begin
                    failures++; $display("FAIL async_data cyc%0d got=%h", i, data_o);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'hFF, NOP, 32'h200, 1'b0, 32'h800, 0, 32'h0);
            checks++;
            if (w_obs !== 99'd0) begin
                failures++; $display("FAIL async_mie0 cyc%0d got=%h exp=0", i, w_obs);
            end
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i == 0) ? 8'h01 : 8'h00, (i == 0) ? EBREAK : NOP, 32'h240, 1'b0,
                 32'h800, 0, 32'h8);
            checks++;
            if (w_obs !== exp_v) begin
                failures++; $display("FAIL prio_seq cyc%0d got=%h exp=%h", i, w_obs, exp_v);
            end
            if (i == 2) begin
                checks++;
                if (data_o !== 32'd3) begin failures++; $display("FAIL prio_cause got=%h exp=3", data_o); end
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, (i == 0) ? 8'h80 : 8'h00, (i == 0) ? ECALL : NOP, 32'h280, (i == 0),
                 32'h800, 0, 32'h8);
            checks++;
            if (w_obs !== 99'd0) begin
                failures++; $display("FAIL jump_squash cyc%0d got=%h exp=0", i, w_obs);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, (i == 0) ? ECALL : NOP, 32'h300, 1'b0, 32'h800, 0, 32'h8);
            checks++;
            if (w_obs !== exp_v) begin
                failures++; $display("FAIL rstmid_pre cyc%0d got=%h exp=%h", i, w_obs, exp_v);
            end
        end
        #2 rst = 1'b1; inst_i = ECALL;
        #1;
        checks++;
        if (w_obs !== 99'd0) begin failures++; $display("FAIL rstmid_immediate got=%h exp=0", w_obs); end
        m_kind = 0; m_k = 0; m_epc = 0; m_cause = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, NOP, 32'h300, 1'b0, 32'h800, 0, 32'h8);
            checks++;
            if (w_obs !== 99'd0) begin
                failures++; $display("FAIL rstmid_quiet cyc%0d got=%h exp=0", i, w_obs);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 0, (i == 0) ? ECALL : NOP, 32'h340, 1'b0, 32'h800, 0, 32'h8);
            checks++;
            if (w_obs !== exp_v) begin
                failures++; $display("FAIL rstmid_after cyc%0d got=%h exp=%h", i, w_obs, exp_v);
            end
        end
    endtask

    task automatic test_vectored();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i == 0) ? 8'h01 : 8'h00, NOP, 32'h400, 1'b0, 32'h801, 0, 32'h8);
            checks++;
            if (w_obs !== exp_v) begin
                failures++; $display("FAIL vec_seq cyc%0d got=%h exp=%h", i, w_obs, exp_v);
            end
            if (i == 4) begin
                checks++;
                if (int_addr_o !== EXP_VEC || int_assert_o !== 1'b1) begin
                    failures++; $display("FAIL vec_target got=%h exp=%h", int_addr_o, EXP_VEC);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0]      in;
        logic [INT_W-1:0] f;
        int               sel;
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 7);
            in  = (sel == 0) ? ECALL : (sel == 1) ? EBREAK : (sel == 2) ? MRET : $urandom;
            f   = ($urandom_range(0, 3) == 0) ? INT_W'($urandom) : '0;
            step(($urandom_range(0, 99) == 0), f, in, $urandom, ($urandom_range(0, 3) == 0),
                 $urandom, $urandom, $urandom);
            checks++;
            if (w_obs !== exp_v) begin
                failures++; $display("FAIL random cyc%0d got=%h exp=%h", i, w_obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_async();
        test_priority();
        test_reset_mid();
        test_vectored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Core-local trap sequencer for the RV32 core. It detects synchronous traps (`ecall`, `ebreak`) and `mret` on the instruction in decode, and asynchronous external interrupts. It then stalls the pipeline through `ctrl`, writes mepc/mcause/mstatus over the CSR write port in fixed order, and issues a one-cycle redirect that ex turns into a jump. It sits directly upstream of `ctrl`: `hold_flag_o` drives `ctrl`'s clint hold input.

## Interface
Parameters:
- `INT_W`, 8, number of external interrupt lines.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous, active-high.
- `int_flag_i` in INT_W: external interrupt lines, level, active-high.
- `inst_i` in 32: instruction in decode.
- `inst_addr_i` in 32: PC of `inst_i`.
- `jump_flag_i` in 1: ex jump this cycle; the decode instruction is being squashed.
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i` in 32 each: current CSR values.
- `we_o` out 1: CSR write enable.
- `waddr_o` out 32: CSR address, with bits 31:12 = 0.
- `data_o` out 32: CSR write data.
- `hold_flag_o` out 1: stall request to `ctrl`.
- `int_assert_o` out 1: redirect strobe to ex.
- `int_addr_o` out 32: redirect target.

## Operation
- Decode: `ecall` = 0x00000073 (cause 11), `ebreak` = 0x00100073 (cause 3), `mret` = 0x30200073.
- Async request: `|int_flag_i && csr_mstatus_i[3]`. Cause is 0x8000000B.
- FSM states:
  - IDLE
  - W_MEPC, W_MCAUSE, W_MSTATUS, ASSERT (trap path)
  - W_MRET, ASSERT_MRET (mret path)
- Acceptance: only in IDLE, and only when `jump_flag_i` = 0.
- Priority: mret/sync > async. A losing async request is not queued; the level is re-evaluated in later IDLE cycles.
- On trap accept, capture:
  - epc = `inst_addr_i` (the instruction in decode is squashed and not executed).
  - cause.
- Trap writes:
  - W_MEPC: addr 0x341, data epc.
  - W_MCAUSE: addr 0x342, data cause.
  - W_MSTATUS: addr 0x300, data = `csr_mstatus_i` with bit3 = 0 and bit7 = old bit3.
- ASSERT: `int_assert_o` = 1, `int_addr_o` = {`csr_mtvec_i`[31:2], 2'b00}.
- mret path:
  - W_MRET: addr 0x300, data = `csr_mstatus_i` with bit3 = old bit7 and bit7 = 1.
  - ASSERT_MRET: `int_addr_o` = `csr_mepc_i`.
- `we_o`, `waddr_o`, `data_o`, `int_assert_o` and `int_addr_o` are decoded from registered state and captured values only. They are 0 in every other state.
- `hold_flag_o` = accept_this_cycle OR (state != IDLE).
- Reset, including mid-sequence: state IDLE, all captures 0, all outputs 0. Partially written CSRs are not rolled back.

## Timing
- Accept in cycle N: `hold_flag_o` = 1 combinationally in N.
- Trap path:
  - N+1: write mepc.
  - N+2: write mcause.
  - N+3: write mstatus.
  - N+4: `int_assert_o` = 1.
  - N+5: IDLE.
  - `hold_flag_o` is high N..N+4 (5 cycles).
- mret path:
  - N+1: write mstatus.
  - N+2: assert.
  - N+3: IDLE.
  - Hold is high N..N+2.
- `int_assert_o` is exactly one cycle wide per accept.
- Back-to-back: a new accept is possible in N+5 (trap) or N+3 (mret).
- Inputs are sampled only in the accept cycle, except that W_MSTATUS/W_MRET read `csr_mstatus_i` live and ASSERT reads `csr_mtvec_i`/`csr_mepc_i` live.

## Configuration
- `INT_CTRL_VECTORED_EN`:
  - Defined: if `csr_mtvec_i`[1:0] = 01 and cause[31] = 1, `int_addr_o` = {mtvec[31:2], 2'b00} + 4 × cause[30:0]. All other cases use the base address.
  - Undefined: `int_addr_o` is always the base address; mtvec[1:0] is ignored.

## Test plan
- `ecall` at 0x00000100, mtvec 0x00000800, mstatus 0x00000008 → writes (0x341, 0x100), (0x342, 11), (0x300, 0x00000080) on N+1..N+3; `int_assert_o` with 0x800 on N+4; hold N..N+4.
- `mret`, mstatus 0x00000080, mepc 0x00000104 → write (0x300, 0x00000088) on N+1; assert with 0x104 on N+2; hold 3 cycles.
- `int_flag_i` = 0x01, MIE = 1, decode PC 0x200 → mepc 0x200, mcause 0x8000000B. With MIE = 0 → no response.
- `ebreak` and an interrupt in the same cycle → cause 3 taken. With `jump_flag_i` = 1 in that cycle → nothing accepted.
- `rst` pulsed in W_MCAUSE → all outputs 0 immediately, no assert follows; a later `ecall` sequences normally.
- `INT_CTRL_VECTORED_EN` defined, mtvec 0x00000801, interrupt → `int_addr_o` = 0x0000082C.
